// File: rtl/pmod_pulse_timestamp_if.sv
// Bundle of trigger inputs and timestamp-pulse outputs for pmod_pulse_timestamp.
// The ts_value/ts_valid signals exist only when PMOD_PULSE_TS_CAPTURE_EN is defined.
interface pmod_pulse_timestamp_if #(
  parameter int NUM_CH  = 2,
  parameter int PULSE_W = 16
);
  logic [NUM_CH-1:0]    trig;
  logic [PULSE_W-1:0]   pulse_len;
  logic [NUM_CH-1:0]    clr_ovf;
  logic [NUM_CH-1:0]    pmod_pin;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH-1:0]    ovf;
`ifdef PMOD_PULSE_TS_CAPTURE_EN
  logic [NUM_CH*32-1:0] ts_value;
  logic [NUM_CH-1:0]    ts_valid;
`endif

  // Master drives triggers; slave is the pulse generator.
  modport master (
    output trig, pulse_len, clr_ovf,
`ifdef PMOD_PULSE_TS_CAPTURE_EN
    input  ts_value, ts_valid,
`endif
    input  pmod_pin, busy, ovf
  );

  modport slave (
    input  trig, pulse_len, clr_ovf,
`ifdef PMOD_PULSE_TS_CAPTURE_EN
    output ts_value, ts_valid,
`endif
    output pmod_pin, busy, ovf
  );
endinterface

// File: rtl/pmod_pulse_timestamp.sv
// Multi-channel active-low timestamp pulse generator with enforced gap, trigger queue
// and sticky overflow. Optional cycle-count capture when PMOD_PULSE_TS_CAPTURE_EN is defined.
module pmod_pulse_timestamp #(
  parameter int NUM_CH     = 2,
  parameter int PULSE_W    = 16,
  parameter int GAP_CYCLES = 100,
  parameter int PEND_MAX   = 3
) (
  input  logic                   sys_clock,
  input  logic                   reset,
  pmod_pulse_timestamp_if.slave  bus
);

  localparam int PEND_W = $clog2(PEND_MAX + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

  // Shared reload value: a zero length still produces a one-cycle pulse.
  logic [PULSE_W-1:0] len_m1;
  assign len_m1 = (bus.pulse_len == '0) ? '0 : bus.pulse_len - PULSE_W'(1);

`ifdef PMOD_PULSE_TS_CAPTURE_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e             state;
    logic [PULSE_W-1:0] len_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PEND_W-1:0]  pend;
    logic               pin_r;
    logic               busy_r;
    logic               ovf_r;
    logic               trig_i;
    logic               pend_full;
`ifdef PMOD_PULSE_TS_CAPTURE_EN
    logic [31:0]        ts_r;
    logic               ts_v_r;
`endif

    assign trig_i    = bus.trig[i];
    assign pend_full = (pend == PEND_W'(PEND_MAX));

    always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
        state   <= IDLE;
        len_cnt <= '0;
        gap_cnt <= '0;
        pend    <= '0;
        pin_r   <= 1'b1;
        busy_r  <= 1'b0;
        ovf_r   <= 1'b0;
`ifdef PMOD_PULSE_TS_CAPTURE_EN
        ts_r    <= '0;
        ts_v_r  <= 1'b0;
`endif
      end else begin
        // NOTE: the overflow set further down is a later non-blocking write to
        // ovf_r, so it overrides this clear when both happen in one cycle.
        if (bus.clr_ovf[i]) ovf_r <= 1'b0;
`ifdef PMOD_PULSE_TS_CAPTURE_EN
        ts_v_r <= 1'b0;
`endif
        unique case (state)
          IDLE: begin
            if (trig_i) begin
              state   <= PULSE;
              len_cnt <= len_m1;
              pin_r   <= 1'b0;
              busy_r  <= 1'b1;
`ifdef PMOD_PULSE_TS_CAPTURE_EN
              ts_r    <= ts_cnt;
              ts_v_r  <= 1'b1;
`endif
            end
          end

          PULSE: begin
            if (trig_i) begin
              if (pend_full) ovf_r <= 1'b1;
              else           pend  <= pend + PEND_W'(1);
            end
            if (len_cnt == '0) begin
              state   <= GAP;
              pin_r   <= 1'b1;
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else begin
              len_cnt <= len_cnt - PULSE_W'(1);
            end
          end

          GAP: begin
            if (gap_cnt == '0) begin
              // A trigger arriving as the gap expires takes the freed slot.
              if ((pend != '0) || trig_i) begin
                state   <= PULSE;
                len_cnt <= len_m1;
                pin_r   <= 1'b0;
                if ((pend != '0) && !trig_i) pend <= pend - PEND_W'(1);
`ifdef PMOD_PULSE_TS_CAPTURE_EN
                ts_r    <= ts_cnt;
                ts_v_r  <= 1'b1;
`endif
              end else begin
                state  <= IDLE;
                busy_r <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
              if (trig_i) begin
                if (pend_full) ovf_r <= 1'b1;
                else           pend  <= pend + PEND_W'(1);
              end
            end
          end

          default: begin
            state  <= IDLE;
            pin_r  <= 1'b1;
            busy_r <= (pend != '0);
          end
        endcase
      end
    end

    assign bus.pmod_pin[i] = pin_r;
    assign bus.busy[i]     = busy_r;
    assign bus.ovf[i]      = ovf_r;
`ifdef PMOD_PULSE_TS_CAPTURE_EN
    assign bus.ts_value[32*i +: 32] = ts_r;
    assign bus.ts_valid[i]          = ts_v_r;
`endif
  end

endmodule

// File: tb/tb_pmod_pulse_timestamp.sv
// Self-checking bench for pmod_pulse_timestamp: vector table, directed corner sequences
// and random triggers checked against a schedule-based reference model.
module tb_pmod_pulse_timestamp;
  localparam int NUM_CH   = 2;
  localparam int PULSE_W  = 16;
  localparam int GAP      = 100;
  localparam int PEND_MAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmod_pulse_timestamp_if #(.NUM_CH(NUM_CH), .PULSE_W(PULSE_W)) bus ();

  pmod_pulse_timestamp #(
    .NUM_CH(NUM_CH), .PULSE_W(PULSE_W), .GAP_CYCLES(GAP), .PEND_MAX(PEND_MAX)
  ) dut (
    .sys_clock (clk),
    .reset     (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  longint cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: each channel remembers when its current pulse started and how
  // long it is; low, gap and idle phases follow from plain arithmetic on that.
  bit     m_has  [NUM_CH];
  longint m_start[NUM_CH];
  longint m_len  [NUM_CH];
  int     m_pend [NUM_CH];
  bit     m_ovf  [NUM_CH];

  function automatic bit m_active(int ch, longint t);
    return m_has[ch] && t >= m_start[ch] && t < m_start[ch] + m_len[ch] + GAP;
  endfunction

  function automatic bit m_low(int ch, longint t);
    return m_has[ch] && t >= m_start[ch] && t < m_start[ch] + m_len[ch];
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_has[ch] = 0; m_start[ch] = 0; m_len[ch] = 0; m_pend[ch] = 0; m_ovf[ch] = 0;
    end
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] t, input logic [PULSE_W-1:0] pl,
                            input logic [NUM_CH-1:0] clr);
    longint n = cyc;
    longint len = (pl == 0) ? 1 : longint'(pl);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit set = 0;
      if (!m_active(ch, n)) begin
        if (t[ch]) begin m_has[ch] = 1; m_start[ch] = n + 1; m_len[ch] = len; end
      end else if (n == m_start[ch] + m_len[ch] + GAP - 1) begin
        if (m_pend[ch] > 0 || t[ch]) begin
          m_pend[ch]  = (m_pend[ch] > 0) ? m_pend[ch] - 1 + int'(t[ch]) : 0;
          m_start[ch] = n + 1;
          m_len[ch]   = len;
        end
      end else if (t[ch]) begin
        if (m_pend[ch] == PEND_MAX) set = 1;
        else m_pend[ch]++;
      end
      if (clr[ch]) m_ovf[ch] = 0;
      if (set)     m_ovf[ch] = 1;
    end
  endtask

  // Output monitors for the directed timing checks.
  int     fall0[$], fall1[$], run0[$], run1[$];
  int     low_run[NUM_CH];
  longint busy_fall[NUM_CH];
  logic [NUM_CH-1:0] prev_pin, prev_busy;
  int     ts_seen[NUM_CH];
  logic [31:0] ts_val[NUM_CH];

  task automatic mon_reset();
    fall0.delete(); fall1.delete(); run0.delete(); run1.delete();
    prev_pin = '1; prev_busy = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      low_run[ch] = 0; busy_fall[ch] = -1; ts_seen[ch] = 0; ts_val[ch] = '0;
    end
  endtask

  task automatic step();
    logic [5:0] exp;
    model_step(bus.trig, bus.pulse_len, bus.clr_ovf);
    @(posedge clk);
    #1;
    cyc++;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp = {4'b0, !m_low(ch, cyc), m_active(ch, cyc) || m_pend[ch] != 0};
      exp = {exp[1:0], 3'b0, m_ovf[ch]};
      check($sformatf("model ch%0d {pin,busy,ovf}", ch),
            {61'b0, bus.pmod_pin[ch], bus.busy[ch], bus.ovf[ch]},
            {61'b0, exp[5], exp[4], exp[0]});
      if (prev_pin[ch] && !bus.pmod_pin[ch]) begin
        if (ch == 0) fall0.push_back(int'(cyc)); else fall1.push_back(int'(cyc));
      end
      if (!bus.pmod_pin[ch]) low_run[ch]++;
      if (!prev_pin[ch] && bus.pmod_pin[ch]) begin
        if (ch == 0) run0.push_back(low_run[ch]); else run1.push_back(low_run[ch]);
        low_run[ch] = 0;
      end
      if (prev_busy[ch] && !bus.busy[ch]) busy_fall[ch] = cyc;
`ifdef PMOD_PULSE_TS_CAPTURE_EN
      if (bus.ts_valid[ch]) begin
        ts_seen[ch]++;
        ts_val[ch] = bus.ts_value[32*ch +: 32];
      end
`endif
    end
    prev_pin  = bus.pmod_pin;
    prev_busy = bus.busy;
  endtask

  task automatic run(input int n);
    bus.trig = '0; bus.clr_ovf = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.trig = '0; bus.clr_ovf = '0; bus.pulse_len = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    mon_reset();
    cyc = 0;
  endtask

  typedef struct {
    logic [1:0]  trig;
    logic [15:0] pl;
    logic [1:0]  clr;
    logic [1:0]  pin;
    logic [1:0]  busy;
    logic [1:0]  ovf;
  } vec_t;

  vec_t vecs[5];
  int burst_left;
  int burst_ch;

  initial begin
    vecs[0] = '{trig: 2'b01, pl: 16'd0, clr: 2'b00, pin: 2'b10, busy: 2'b01, ovf: 2'b00};
    vecs[1] = '{trig: 2'b00, pl: 16'd0, clr: 2'b00, pin: 2'b11, busy: 2'b01, ovf: 2'b00};
    vecs[2] = '{trig: 2'b10, pl: 16'd2, clr: 2'b11, pin: 2'b01, busy: 2'b11, ovf: 2'b00};
    vecs[3] = '{trig: 2'b00, pl: 16'd9, clr: 2'b00, pin: 2'b01, busy: 2'b11, ovf: 2'b00};
    vecs[4] = '{trig: 2'b00, pl: 16'd9, clr: 2'b00, pin: 2'b11, busy: 2'b11, ovf: 2'b00};

    bus.trig = '0; bus.clr_ovf = '0; bus.pulse_len = '0;
    cyc = 0;
    model_reset();
    mon_reset();

    // Idle after reset.
    do_reset();
    check("reset pin", 64'(bus.pmod_pin), 64'(2'b11));
    check("reset busy", 64'(bus.busy), 64'(2'b00));
    check("reset ovf", 64'(bus.ovf), 64'(2'b00));
    run(50);
    check("idle no pulses", 64'(fall0.size() + fall1.size()), 64'd0);

    // Vector table: pulse_len=0 on ch0, then pulse_len=2 on ch1.
    do_reset();
    for (int v = 0; v < 5; v++) begin
      bus.trig = vecs[v].trig; bus.pulse_len = vecs[v].pl; bus.clr_ovf = vecs[v].clr;
      step();
      check($sformatf("vec%0d pin", v), 64'(bus.pmod_pin), 64'(vecs[v].pin));
      check($sformatf("vec%0d busy", v), 64'(bus.busy), 64'(vecs[v].busy));
      check($sformatf("vec%0d ovf", v), 64'(bus.ovf), 64'(vecs[v].ovf));
    end
    run(150);
    check("vec zero-len run", 64'(run0[0]), 64'd1);

    // Single pulse, pulse_len=5.
    do_reset();
    bus.pulse_len = 16'd5;
    run(10);
    bus.trig = 2'b01; step();
    run(200);
    check("single falls", 64'(fall0.size()), 64'd1);
    check("single start", 64'(fall0[0]), 64'd11);
    check("single low len", 64'(run0[0]), 64'd5);
    check("single busy end", 64'(busy_fall[0]), 64'd116);
    check("single ch1 quiet", 64'(fall1.size()), 64'd0);

    // Four strobes queued behind the first pulse.
    do_reset();
    bus.pulse_len = 16'd4;
    run(10);
    for (int k = 0; k < 4; k++) begin
      bus.trig = 2'b01; step();
      bus.trig = 2'b00; step();
    end
    run(480);
    check("queue falls", 64'(fall0.size()), 64'd4);
    check("queue start0", 64'(fall0[0]), 64'd11);
    check("queue start1", 64'(fall0[1]), 64'd115);
    check("queue start2", 64'(fall0[2]), 64'd219);
    check("queue start3", 64'(fall0[3]), 64'd323);
    for (int k = 0; k < 4; k++) check($sformatf("queue len%0d", k), 64'(run0[k]), 64'd4);
    check("queue ovf", 64'(bus.ovf[0]), 64'd0);
    check("queue busy end", 64'(busy_fall[0]), 64'd427);

    // Overflow: five back-to-back triggers on ch1, then clear and clear-vs-set.
    do_reset();
    bus.pulse_len = 16'd3;
    run(10);
    bus.trig = 2'b10;
    for (int k = 0; k < 5; k++) step();
    run(20 - int'(cyc));
    check("ovf set", 64'(bus.ovf[1]), 64'd1);
    bus.clr_ovf = 2'b10; step();
    check("ovf cleared", 64'(bus.ovf[1]), 64'd0);
    run(30 - int'(cyc));
    bus.trig = 2'b10; bus.clr_ovf = 2'b10; step();
    check("ovf set beats clear", 64'(bus.ovf[1]), 64'd1);
    run(500);
    check("ovf pulses", 64'(fall1.size()), 64'd4);
    check("ovf sticky", 64'(bus.ovf[1]), 64'd1);
    check("ovf ch0 quiet", 64'(bus.ovf[0]), 64'd0);

    // Reset in the middle of a long pulse with a trigger queued.
    do_reset();
    bus.pulse_len = 16'd1000;
    run(5);
    bus.trig = 2'b01; step(); step();
    run(20);
    check("long pulse low", 64'(bus.pmod_pin[0]), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset pin", 64'(bus.pmod_pin), 64'(2'b11));
    check("async reset busy", 64'(bus.busy), 64'(2'b00));
    do_reset();
    bus.pulse_len = 16'd1000;
    run(300);
    check("queue discarded", 64'(fall0.size()), 64'd0);

`ifdef PMOD_PULSE_TS_CAPTURE_EN
    do_reset();
    bus.pulse_len = 16'd2;
    run(10);
    bus.trig = 2'b01; step();
    run(9);
    bus.trig = 2'b10; step();
    run(20);
    check("ts valid ch0", 64'(ts_seen[0]), 64'd1);
    check("ts valid ch1", 64'(ts_seen[1]), 64'd1);
    check("ts delta", 64'(ts_val[1] - ts_val[0]), 64'd10);
`endif

    // Random triggers, bursts, clears and pulse lengths against the model.
    do_reset();
    burst_left = 0;
    burst_ch = 0;
    for (int k = 0; k < 4000; k++) begin
      logic [1:0] t;
      t[0] = ($urandom_range(0, 99) < 4);
      t[1] = ($urandom_range(0, 99) < 4);
      if (burst_left == 0 && $urandom_range(0, 149) == 0) begin
        burst_left = 6;
        burst_ch = int'($urandom_range(0, 1));
      end
      if (burst_left > 0) begin
        t[burst_ch] = 1'b1;
        burst_left--;
      end
      bus.trig = t;
      bus.clr_ovf = {($urandom_range(0, 49) == 0), ($urandom_range(0, 49) == 0)};
      if ($urandom_range(0, 9) == 0) bus.pulse_len = 16'($urandom_range(0, 9));
      step();
    end
    run(600);
    check("random drained", 64'(bus.busy), 64'(2'b00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
